bus_arbiter4: RTL and testbench
===============================

BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter: WIDTH, 32, data width of each requester port and of the shared bus.
REQ-002 Parameter: MAXBURST, 8, maximum beats per locked grant before forced release (legal range 1..15).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: req  input  4  request per requester; bit i belongs to requester i.
REQ-007 Port: lock  input  4  per-requester burst lock; sampled with req.
REQ-008 Port: din0, din1, din2, din3  input  WIDTH each  requester data words.
REQ-009 Port: bus_ready  input  1  sink accepts the current beat.
REQ-010 Port: gnt  output  4  one-hot grant, registered.
REQ-011 Port: sel  output  2  binary index of the granted requester, registered.
REQ-012 Port: bus_valid  output  1  shared bus carries a valid beat, registered.
REQ-013 Port: bus_data  output  WIDTH  shared bus data, equal to din[sel].

Function
REQ-014 The FSM SHALL have two states: IDLE and BUSY.
REQ-015 In IDLE with req != 0, the block SHALL pick the first set req bit at or after rr_ptr, searching upward modulo 4.
REQ-016 The pick SHALL load gnt, sel and bus_valid=1 on the next edge and enter BUSY, giving a latency of 1 cycle from req to gnt.
REQ-017 In IDLE with req == 0, the block SHALL hold gnt=0 and bus_valid=0.
REQ-018 bus_data SHALL be combinational din[sel] and is don't-care while bus_valid=0.
REQ-019 A beat SHALL transfer on every edge where bus_valid and bus_ready are both 1.
REQ-020 On a transfer, the block SHALL stay BUSY with the same grant when lock[sel]=1, req[sel]=1 and beat_cnt+1 < MAXBURST, and SHALL increment beat_cnt.
REQ-021 In all other transfer cases, the block SHALL release: gnt=0, bus_valid=0, rr_ptr=(sel+1) mod 4, beat_cnt=0, next state IDLE.
REQ-022 After a release, the block SHALL spend one IDLE cycle before any new grant.
REQ-023 In BUSY with req[sel]=0 and no transfer (withdrawal), the block SHALL return to IDLE, clear gnt, bus_valid and beat_cnt, and leave rr_ptr unchanged.
REQ-024 If withdrawal and transfer occur on the same edge, the transfer SHALL take precedence (REQ-021 applies).
REQ-025 In BUSY with bus_ready=0, gnt, sel, bus_valid and beat_cnt SHALL hold unchanged.
REQ-026 Requests from requesters other than sel SHALL be ignored while BUSY.
REQ-027 gnt SHALL always be zero or one-hot, and gnt != 0 SHALL hold if and only if bus_valid=1.
REQ-028 beat_cnt SHALL be 4 bits wide and SHALL never reach MAXBURST.

Reset
REQ-029 On reset, the block SHALL set state=IDLE, rr_ptr=0, beat_cnt=0, gnt=0, sel=0 and bus_valid=0 on the next edge.
REQ-030 Reset SHALL override any in-flight burst, with no transfer credited on that edge.

Structure
REQ-031 State encodings (IDLE=0, BUSY=1), NREQ=4 and the MAXBURST default SHALL live in the shared package/include file.
REQ-032 The block SHALL use one sub-module, rr_pick4: combinational, with inputs req[3:0] and ptr[1:0], and outputs found and idx[1:0].
REQ-033 bus_data SHALL be built from the team's existing 32-bit 4:1 mux cell, driven by sel.

Verification
REQ-034 Reset, then req=4'b0101 with bus_ready=1 held -> gnt=0001 in cycle 1, release, IDLE, then gnt=0100, then gnt=0001; alternation confirms round-robin.
REQ-035 req=4'b1000, lock=4'b1000, MAXBURST=8, bus_ready=1 -> exactly 8 consecutive beats with bus_data=din3, then release and rr_ptr=0.
REQ-036 Grant to requester 1, bus_ready=0 for 5 cycles -> gnt=0010, bus_valid=1 and bus_data=din1 stable throughout; the beat transfers on the first cycle with bus_ready=1.
REQ-037 Grant to requester 2, then req[2] dropped with bus_ready=0 -> next cycle gnt=0, bus_valid=0, and the next grant search still starts at 2.
REQ-038 Mid-burst (beat 3 of a lock on requester 0), assert reset for 1 cycle -> all outputs 0 the next cycle; with req=4'b0001 the next grant is 0001 and beat_cnt starts from 0.
REQ-039 Random req, lock and bus_ready for 10k cycles -> gnt always one-hot or zero, no grant held past MAXBURST beats, and every requester holding req is granted within 4 grants.

Source files
------------

// File: rtl/bus_arbiter4_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter4_pkg
// Shared definitions for the 4-way round-robin bus arbiter:
//   - NREQ             : number of requesters
//   - MAXBURST_DEFAULT : default maximum beats per locked grant
//   - arb_state_e      : arbiter FSM state encoding (IDLE=0, BUSY=1)
//   - idx_to_onehot()  : 2-bit index to 4-bit one-hot grant vector
// ---------------------------------------------------------------------------
package bus_arbiter4_pkg;

    localparam int NREQ             = 4;
    localparam int MAXBURST_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker: finds the first set request bit at or
// after ptr, searching upward modulo 4.
// Ports:
//   req   : input  [3:0] request vector
//   ptr   : input  [1:0] search start position
//   found : output       at least one request is set
//   idx   : output [1:0] index of the chosen request (ptr when none found)
// ---------------------------------------------------------------------------
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [7:0] req_dbl_s;
    logic [3:0] req_rot_s;
    logic [1:0] offset_s;

    // Rotate so that bit 0 of req_rot_s corresponds to requester ptr; a plain
    // priority encode on the rotated vector then gives the upward search.
    assign req_dbl_s = {req, req} >> ptr;
    assign req_rot_s = req_dbl_s[3:0];

    // Priority-encode the rotated request vector.
    always_comb begin
        found    = 1'b1;
        offset_s = 2'd0;
        casez (req_rot_s)
            4'b???1: offset_s = 2'd0;
            4'b??10: offset_s = 2'd1;
            4'b?100: offset_s = 2'd2;
            4'b1000: offset_s = 2'd3;
            default: begin
                found    = 1'b0;
                offset_s = 2'd0;
            end
        endcase
    end

    // Offset is relative to ptr; 2-bit addition wraps modulo 4.
    assign idx = ptr + offset_s;

endmodule

// File: rtl/mux4_32.sv
// ---------------------------------------------------------------------------
// mux4_32
// 32-bit 4:1 multiplexer cell.
// Ports:
//   d0..d3 : input  [31:0] data inputs
//   s      : input  [1:0]  select
//   y      : output [31:0] selected data
// ---------------------------------------------------------------------------
module mux4_32 (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [1:0]  s,
    output logic [31:0] y
);

    // Select one of four data words.
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = 32'd0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter4.sv
// ---------------------------------------------------------------------------
// bus_arbiter4
// Four-requester round-robin arbiter with optional locked bursts onto one
// shared bus. Grant, select and valid are registered; bus data is the
// selected requester's word.
// Ports:
//   clk        : input         rising-edge clock
//   reset      : input         synchronous active-high reset
//   req        : input  [3:0]  request per requester
//   lock       : input  [3:0]  burst lock per requester
//   din0..din3 : input  [W-1:0] requester data words
//   bus_ready  : input         sink accepts the current beat
//   gnt        : output [3:0]  one-hot grant (registered)
//   sel        : output [1:0]  granted requester index (registered)
//   bus_valid  : output        shared bus beat valid (registered)
//   bus_data   : output [W-1:0] shared bus data, din[sel]
// ---------------------------------------------------------------------------
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAXBURST = MAXBURST_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  lock,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic             bus_ready,
    output logic [NREQ-1:0]  gnt,
    output logic [1:0]       sel,
    output logic             bus_valid,
    output logic [WIDTH-1:0] bus_data
);

    localparam logic [4:0] MAXBURST_W = 5'(MAXBURST);
    localparam int         NSLICE     = (WIDTH + 31) / 32;
    localparam int         PADW       = NSLICE * 32;

    arb_state_e      state_r;
    arb_state_e      state_nxt_s;
    logic [1:0]      rr_ptr_r;
    logic [1:0]      rr_ptr_nxt_s;
    logic [3:0]      beat_cnt_r;
    logic [3:0]      beat_cnt_nxt_s;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] gnt_nxt_s;
    logic [1:0]      sel_r;
    logic [1:0]      sel_nxt_s;
    logic            bus_valid_r;
    logic            bus_valid_nxt_s;

    logic            found_s;
    logic [1:0]      pick_idx_s;
    logic            xfer_s;
    logic            keep_s;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (rr_ptr_r),
        .found (found_s),
        .idx   (pick_idx_s)
    );

    assign xfer_s = bus_valid_r & bus_ready;
    // Burst continues only while the owner still requests with lock set and
    // the beat just transferred is not the last one allowed.
    assign keep_s = lock[sel_r] & req[sel_r] &
                    (({1'b0, beat_cnt_r} + 5'd1) < MAXBURST_W);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                // A transfer outranks a simultaneous withdrawal.
                if (xfer_s) begin
                    if (keep_s) begin
                        state_nxt_s = BUSY;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (!req[sel_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values of grant, select, valid, pointer, count.
    always_comb begin
        gnt_nxt_s       = gnt_r;
        sel_nxt_s       = sel_r;
        bus_valid_nxt_s = bus_valid_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        beat_cnt_nxt_s  = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    gnt_nxt_s       = idx_to_onehot(pick_idx_s);
                    sel_nxt_s       = pick_idx_s;
                    bus_valid_nxt_s = 1'b1;
                    beat_cnt_nxt_s  = 4'd0;
                end else begin
                    gnt_nxt_s       = 4'd0;
                    bus_valid_nxt_s = 1'b0;
                end
            end
            BUSY: begin
                if (xfer_s) begin
                    if (keep_s) begin
                        beat_cnt_nxt_s = beat_cnt_r + 4'd1;
                    end else begin
                        // Release: next search starts just past the owner.
                        gnt_nxt_s       = 4'd0;
                        bus_valid_nxt_s = 1'b0;
                        rr_ptr_nxt_s    = sel_r + 2'd1;
                        beat_cnt_nxt_s  = 4'd0;
                    end
                end else if (!req[sel_r]) begin
                    // Withdrawal: pointer stays put.
                    gnt_nxt_s       = 4'd0;
                    bus_valid_nxt_s = 1'b0;
                    beat_cnt_nxt_s  = 4'd0;
                end else begin
                    // Stalled by the sink: everything holds.
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                gnt_nxt_s       = 4'd0;
                bus_valid_nxt_s = 1'b0;
                beat_cnt_nxt_s  = 4'd0;
            end
        endcase
    end

    // Registered outputs, round-robin pointer and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_r       <= 4'd0;
            sel_r       <= 2'd0;
            bus_valid_r <= 1'b0;
            rr_ptr_r    <= 2'd0;
            beat_cnt_r  <= 4'd0;
        end else begin
            gnt_r       <= gnt_nxt_s;
            sel_r       <= sel_nxt_s;
            bus_valid_r <= bus_valid_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            beat_cnt_r  <= beat_cnt_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign bus_valid = bus_valid_r;

    // Shared data path: WIDTH is covered by as many 32-bit mux cells as needed.
    logic [PADW-1:0] d0_pad_s;
    logic [PADW-1:0] d1_pad_s;
    logic [PADW-1:0] d2_pad_s;
    logic [PADW-1:0] d3_pad_s;
    logic [PADW-1:0] data_pad_s;

    assign d0_pad_s = PADW'(din0);
    assign d1_pad_s = PADW'(din1);
    assign d2_pad_s = PADW'(din2);
    assign d3_pad_s = PADW'(din3);

    for (genvar g = 0; g < NSLICE; g++) begin : g_mux
        mux4_32 u_mux (
            .d0 (d0_pad_s[g*32 +: 32]),
            .d1 (d1_pad_s[g*32 +: 32]),
            .d2 (d2_pad_s[g*32 +: 32]),
            .d3 (d3_pad_s[g*32 +: 32]),
            .s  (sel_r),
            .y  (data_pad_s[g*32 +: 32])
        );
    end

    assign bus_data = data_pad_s[WIDTH-1:0];

endmodule

// File: tb/tb_bus_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter4
// Self-checking bench for bus_arbiter4: a table of per-cycle vectors for the
// round-robin, stall, withdrawal and precedence cases, hand-written locked
// burst and reset-mid-burst sequences, then a random run with invariant and
// fairness checks.
// ---------------------------------------------------------------------------
module tb_bus_arbiter4;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic        bus_ready;
    logic [31:0] din_arr [4];
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        bus_valid;
    logic [31:0] bus_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic [3:0] e_gnt;
        logic [1:0] e_sel;
        logic       e_valid;
    } vec_t;

    vec_t vecs [22];

    bus_arbiter4 #(.WIDTH(32), .MAXBURST(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .din0      (din_arr[0]),
        .din1      (din_arr[1]),
        .din2      (din_arr[2]),
        .din3      (din_arr[3]),
        .bus_ready (bus_ready),
        .gnt       (gnt),
        .sel       (sel),
        .bus_valid (bus_valid),
        .bus_data  (bus_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic ev);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".sel"}, 32'(sel), 32'(es));
        chk({tag, ".valid"}, 32'(bus_valid), 32'(ev));
        if (ev) chk({tag, ".data"}, bus_data, din_arr[es]);
    endtask

    // Count transferred beats of the current grant until it releases.
    task automatic count_burst(input string tag, input logic [3:0] eg, input logic [1:0] es);
        int beats;
        beats = 0;
        for (int c = 0; c < 20 && bus_valid; c++) begin
            chk($sformatf("%s.beat%0d.gnt", tag, beats), 32'(gnt), 32'(eg));
            chk($sformatf("%s.beat%0d.data", tag, beats), bus_data, din_arr[es]);
            beats++;
            tick();
        end
        chk({tag, ".beats"}, 32'(beats), 32'(MB));
        chk({tag, ".released"}, 32'(bus_valid), 32'd0);
    endtask

    int         wait_cnt [4];
    int         burst_beats;
    logic       v_b;
    logic [1:0] s_b;
    logic [3:0] rq;
    logic       rd;
    logic       completed;

    initial begin
        din_arr[0] = 32'hA000_0000;
        din_arr[1] = 32'hB111_1111;
        din_arr[2] = 32'hC222_2222;
        din_arr[3] = 32'hD333_3333;

        //            req      lock     rdy   gnt      sel   valid
        vecs[0]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[1]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[2]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1};
        vecs[3]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        vecs[4]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[5]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[6]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[7]  = '{4'b1011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[8]  = '{4'b1011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[9]  = '{4'b1111, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[10] = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[11] = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[12] = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0};
        vecs[13] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
        vecs[15] = '{4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[16] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        vecs[17] = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1};
        vecs[18] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0};
        vecs[19] = '{4'b1001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[20] = '{4'b1001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[21] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};

        // Reset with active inputs: outputs must stay cleared.
        reset     = 1'b1;
        req       = 4'b0101;
        lock      = 4'b1111;
        bus_ready = 1'b1;
        tick();
        tick();
        chk_outs("reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;

        // Round-robin, stall, withdrawal, transfer-over-withdrawal table.
        for (int i = 0; i < 22; i++) begin
            req       = vecs[i].req;
            lock      = vecs[i].lock;
            bus_ready = vecs[i].rdy;
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_sel, vecs[i].e_valid);
        end

        // Locked burst on requester 3 (pointer is 1 here): MB beats then release.
        req       = 4'b1000;
        lock      = 4'b1000;
        bus_ready = 1'b1;
        tick();
        chk_outs("burst3.grant", 4'b1000, 2'd3, 1'b1);
        count_burst("burst3", 4'b1000, 2'd3);
        // Pointer must now be 0: with req 1001, requester 0 wins.
        req  = 4'b1001;
        lock = 4'b0000;
        tick();
        chk_outs("burst3.ptr0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        chk_outs("burst3.rel", 4'b0000, 2'd0, 1'b0);

        // Reset during beat 3 of a locked burst on requester 0.
        req  = 4'b0001;
        lock = 4'b0001;
        tick();
        chk_outs("rstburst.grant", 4'b0001, 2'd0, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_outs("rstburst.reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        tick();
        chk_outs("rstburst.regrant", 4'b0001, 2'd0, 1'b1);
        count_burst("rstburst", 4'b0001, 2'd0);
        req  = 4'b0000;
        lock = 4'b0000;
        tick();

        // Random run: form, burst-length and fairness invariants.
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        burst_beats = 0;
        for (int c = 0; c < 10000; c++) begin
            req       = 4'($urandom);
            lock      = 4'($urandom);
            bus_ready = ($urandom_range(0, 3) != 0);
            v_b       = bus_valid;
            s_b       = sel;
            rq        = req;
            rd        = bus_ready;
            tick();
            chk("rand.onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("rand.gnt_iff_valid", 32'(gnt != 4'd0), 32'(bus_valid));
            if (v_b && rd) burst_beats++;
            chk("rand.burst_len", 32'(burst_beats <= MB), 32'd1);
            if (gnt == 4'd0) burst_beats = 0;
            completed = v_b && rd && (gnt == 4'd0);
            for (int i = 0; i < 4; i++) begin
                if (gnt[i] || !rq[i]) begin
                    wait_cnt[i] = 0;
                end else if (completed && (32'(s_b) != i)) begin
                    wait_cnt[i]++;
                    chk($sformatf("rand.fair%0d", i), 32'(wait_cnt[i] <= 3), 32'd1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
